// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the single register-file write port between writeback
//               and the multi-cycle unit. Tracks reserved registers for decode
//               hazards and stalls the pipe when the secondary unit starves.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_val,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_val,
  output logic        mdu_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_rd,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  output logic        hazard,
  output logic        pipe_stall,
  output logic        rsv_err,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_din,
  output logic        reg_we
);

  localparam logic [0:0]       c_st_run   = 1'b0;
  localparam logic [0:0]       c_st_stall = 1'b1;
  localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic [31:0]      r_busy;
  logic [31:0]      w_busy_nxt;
  logic             r_rsv_err;
  logic             w_rsv_err_nxt;
  logic             w_stall;
  logic             w_wb_req;
  logic             w_mdu_grant;
  logic             w_sel_we;
  logic [4:0]       w_addr;
  logic [31:0]      w_din;

  // ---------------------------------------------------------------------------
  // Stall state machine: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_run;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall state machine: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      c_st_run: begin
        if (mdu_valid && !w_mdu_grant) begin
          w_wait_cnt_nxt = r_wait_cnt + c_cnt_one;
          if (w_wait_cnt_nxt == c_max_wait) begin
            w_state_nxt = c_st_stall;
          end
        end else begin
          w_wait_cnt_nxt = '0;
        end
      end
      c_st_stall: begin
        // Leave only once the starved result has actually been taken.
        if (w_mdu_grant) begin
          w_state_nxt    = c_st_run;
          w_wait_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = c_st_run;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall state machine: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_stall = (r_state == c_st_stall);
  end

  // ---------------------------------------------------------------------------
  // Write-port grant (zero latency)
  // ---------------------------------------------------------------------------
  always_comb begin
    // While stalled the WB stage will re-present its write, so it is ignored.
    w_wb_req    = !w_stall && (wb_rd != 5'd0);
    w_mdu_grant = mdu_valid && (w_stall || (wb_rd == 5'd0));
    w_sel_we    = 1'b0;
    w_addr      = 5'd0;
    w_din       = 32'd0;
    if (w_wb_req) begin
      w_sel_we = 1'b1;
      w_addr   = wb_rd;
      w_din    = wb_val;
    end else if (w_mdu_grant) begin
      w_sel_we = 1'b1;
      w_addr   = mdu_rd;
      w_din    = mdu_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt    = r_busy;
    w_rsv_err_nxt = r_rsv_err;
    if (w_mdu_grant) begin
      w_busy_nxt[mdu_rd] = 1'b0;
    end
    // Reserve is applied after the clear so a same-cycle set wins.
    if (rsv_valid && (rsv_rd != 5'd0)) begin
      if (r_busy[rsv_rd]) begin
        w_rsv_err_nxt = 1'b1;
      end
      w_busy_nxt[rsv_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_rsv_err <= w_rsv_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mdu_ready  = w_mdu_grant;
  assign reg_addr   = w_addr;
  assign reg_din    = w_din;
  assign reg_we     = w_sel_we && !rst && (w_addr != 5'd0);
  assign hazard     = r_busy[q_rs] | r_busy[q_rt];
  assign pipe_stall = w_stall;
  assign rsv_err    = r_rsv_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_val;
  logic        mdu_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_rd;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        hazard;
  logic        pipe_stall;
  logic        rsv_err;
  logic [4:0]  reg_addr;
  logic [31:0] reg_din;
  logic        reg_we;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        rdy;
  } wr_exp_t;

  wr_exp_t exp_q[$];

  regfile_write_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .wb_rd(wb_rd), .wb_val(wb_val),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_val(mdu_val), .mdu_ready(mdu_ready),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .q_rs(q_rs), .q_rt(q_rt),
    .hazard(hazard), .pipe_stall(pipe_stall), .rsv_err(rsv_err),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_we(reg_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] din, input logic rdy);
    wr_exp_t e;
    e.tag = tag; e.we = we; e.addr = addr; e.din = din; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  task automatic check_wr();
    wr_exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".we"},   {31'd0, reg_we},    {31'd0, e.we});
      chk({e.tag, ".addr"}, {27'd0, reg_addr},  {27'd0, e.addr});
      chk({e.tag, ".din"},  reg_din,            e.din);
      chk({e.tag, ".rdy"},  {31'd0, mdu_ready}, {31'd0, e.rdy});
    end
  endtask

  // Drive one cycle of inputs just after the edge, leave time at mid-cycle.
  task automatic step(input logic [4:0] wrd, input logic [31:0] wval,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mval,
                      input logic rv, input logic [4:0] rrd,
                      input logic [4:0] qs, input logic [4:0] qt);
    @(posedge clk);
    #1;
    wb_rd = wrd; wb_val = wval;
    mdu_valid = mv; mdu_rd = mrd; mdu_val = mval;
    rsv_valid = rv; rsv_rd = rrd;
    q_rs = qs; q_rt = qt;
    #4;
  endtask

  initial begin
    rst = 1'b1;
    wb_rd = 5'd5; wb_val = 32'h1;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_val = 32'd0;
    rsv_valid = 1'b0; rsv_rd = 5'd0;
    q_rs = 5'd5; q_rt = 5'd0;
    #2;
    chk("reset_we",     {31'd0, reg_we},     32'd0);
    chk("reset_stall",  {31'd0, pipe_stall}, 32'd0);
    chk("reset_err",    {31'd0, rsv_err},    32'd0);
    chk("reset_hazard", {31'd0, hazard},     32'd0);
    #10;
    rst = 1'b0;

    // WB write wins with mdu idle
    exp_wr("wb_write", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    step(5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_wr();

    // Reserve r9, no bypass on the same cycle
    exp_wr("rsv9_idle", 1'b0, 5'd0, 32'd0, 1'b0);
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    check_wr();
    chk("hz_rsv9_same", {31'd0, hazard}, 32'd0);

    // Secondary commit of r9
    exp_wr("mdu_r9", 1'b1, 5'd9, 32'h12, 1'b1);
    step(5'd0, 32'd0, 1'b1, 5'd9, 32'h12, 1'b0, 5'd0, 5'd9, 5'd0);
    check_wr();
    chk("hz_r9_busy", {31'd0, hazard}, 32'd1);

    exp_wr("idle_a", 1'b0, 5'd0, 32'd0, 1'b0);
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    check_wr();
    chk("hz_r9_clear", {31'd0, hazard}, 32'd0);

    // Reserve r7, query through q_rt
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd7);
    chk("hz_rsv7_same", {31'd0, hazard}, 32'd0);
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    chk("hz_r7_busy", {31'd0, hazard}, 32'd1);
    chk("err_clean", {31'd0, rsv_err}, 32'd0);
    exp_wr("mdu_r7", 1'b1, 5'd7, 32'h77, 1'b1);
    step(5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0, 5'd7);
    check_wr();
    chk("hz_r7_commit_cycle", {31'd0, hazard}, 32'd1);

    // Double reservation of r7
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd7);
    chk("hz_r7_clear", {31'd0, hazard}, 32'd0);
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    chk("err_after_first", {31'd0, rsv_err}, 32'd0);
    chk("hz_r7_rsv", {31'd0, hazard}, 32'd1);
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("err_set", {31'd0, rsv_err}, 32'd1);
    chk("hz_r7_still", {31'd0, hazard}, 32'd1);

    // Same-cycle reserve and commit of r8: set wins
    exp_wr("mdu_r8", 1'b1, 5'd8, 32'h88, 1'b1);
    step(5'd0, 32'd0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 5'd0, 5'd0);
    check_wr();
    chk("err_sticky", {31'd0, rsv_err}, 32'd1);

    // WAW: WB to busy r8 still writes, busy stays
    exp_wr("waw_r8", 1'b1, 5'd8, 32'h5A, 1'b0);
    step(5'd8, 32'h5A, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd0);
    check_wr();
    chk("hz_r8_setwins", {31'd0, hazard}, 32'd1);
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd0);
    chk("hz_r8_after_waw", {31'd0, hazard}, 32'd1);

    // Starvation: four denied cycles, then forced stall
    for (int i = 0; i < 4; i++) begin
      exp_wr("starve_wb", 1'b1, 5'(3 + i), 32'(3 + i), 1'b0);
      step(5'(3 + i), 32'(3 + i), 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 5'd0, 5'd0);
      check_wr();
      chk("starve_nostall", {31'd0, pipe_stall}, 32'd0);
    end
    exp_wr("stall_grant", 1'b1, 5'd10, 32'hAA, 1'b1);
    step(5'd11, 32'hB, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 5'd0, 5'd0);
    check_wr();
    chk("stall_on", {31'd0, pipe_stall}, 32'd1);
    exp_wr("post_stall_wb", 1'b1, 5'd11, 32'hB, 1'b0);
    step(5'd11, 32'hB, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_wr();
    chk("stall_off", {31'd0, pipe_stall}, 32'd0);

    // Counter clears on a non-denied cycle: 3 denied, gap, 3 denied, no stall
    for (int i = 0; i < 8; i++) begin
      step(5'd3, 32'h3, (i % 4) != 3, 5'd10, 32'hAA, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("cnt_clear_nostall", {31'd0, pipe_stall}, 32'd0);
    end

    // Stall holds while mdu_valid is low; r0 commit gives ready without write
    for (int i = 0; i < 4; i++) begin
      step(5'd4, 32'h4, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 5'd0, 5'd0);
    end
    exp_wr("stall_wb_ignored", 1'b0, 5'd0, 32'd0, 1'b0);
    step(5'd12, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_wr();
    chk("stall_hold_a", {31'd0, pipe_stall}, 32'd1);
    exp_wr("r0_commit", 1'b0, 5'd0, 32'h99, 1'b1);
    step(5'd12, 32'hC, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 5'd0, 5'd0);
    check_wr();
    chk("stall_hold_b", {31'd0, pipe_stall}, 32'd1);
    exp_wr("wb_replay", 1'b1, 5'd12, 32'hC, 1'b0);
    step(5'd12, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_wr();
    chk("stall_release", {31'd0, pipe_stall}, 32'd0);

    // Asynchronous reset in the middle of a stall
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      step(5'd4, 32'h4, 1'b1, 5'd13, 32'hD, 1'b0, 5'd0, 5'd13, 5'd0);
    end
    step(5'd5, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd13, 5'd0);
    chk("pre_rst_stall", {31'd0, pipe_stall}, 32'd1);
    chk("pre_rst_hazard", {31'd0, hazard}, 32'd1);
    chk("pre_rst_err", {31'd0, rsv_err}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    exp_wr("rst_async_wr", 1'b0, 5'd5, 32'h55, 1'b0);
    check_wr();
    chk("rst_async_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_async_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_async_err", {31'd0, rsv_err}, 32'd0);
    #2;
    rst = 1'b0;

    // Late result after reset is still written
    exp_wr("late_r13", 1'b1, 5'd13, 32'hD, 1'b1);
    step(5'd0, 32'd0, 1'b1, 5'd13, 32'hD, 1'b0, 5'd0, 5'd13, 5'd0);
    check_wr();
    chk("late_hazard", {31'd0, hazard}, 32'd0);
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 5'd13, 5'd0);
    step(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd13, 5'd0);
    chk("rsv13_after_rst_err", {31'd0, rsv_err}, 32'd0);
    chk("rsv13_after_rst_hz", {31'd0, hazard}, 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
